mult_error_accum: RTL

Streaming error-metric accumulator placed directly downstream of the 16-bit signed multiplier (approximate low-partial-product variant). Each accepted sample pairs the approximate product with the exact product for the same operands. The block computes the absolute error distance of each sample and accumulates, over a run of N_SAMPLES accepted samples:

- the sum of error distances,
- the maximum error distance,
- the count of erroneous samples.

Results are reported with a done pulse, for on-chip characterisation of approximate multipliers.

---
 rtl/mult_error_accum.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mult_error_accum.sv
// Error-metric accumulator for approximate multiplier characterisation.
// Compares approximate and exact products and reports the sum, maximum and count of errors over a run.
module mult_error_accum #(
    parameter int N_SAMPLES = 256,
    parameter int PROD_W    = 32,
    parameter int ACC_W     = 48,
    parameter int CNT_W     = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_valid,
    input  logic [PROD_W-1:0]   i_approx,
    input  logic [PROD_W-1:0]   i_exact,
    output logic                o_ready,
    output logic                o_busy,
    output logic                o_done,
    output logic [ACC_W-1:0]    o_sum_ed,
    output logic [PROD_W:0]     o_max_ed,
    output logic [CNT_W-1:0]    o_err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   sample_cnt;
    logic [CNT_W-1:0]   sample_cnt_next;
    logic               drain_cnt;
    logic               drain_cnt_next;
    logic               done_next;
    logic               clear;
    logic               accept;

    logic [PROD_W:0]    diff;
    logic [PROD_W:0]    ed;
    logic               s1_valid;
    logic [PROD_W:0]    s1_ed;
    logic               s1_nz;

    logic [ACC_W:0]     sum_wide;
    logic [ACC_W-1:0]   sum_sat;

    // Control state and the registered done pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            drain_cnt  <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            state      <= state_next;
            sample_cnt <= sample_cnt_next;
            drain_cnt  <= drain_cnt_next;
            o_done     <= done_next;
        end
    end

    always_comb begin
        state_next      = state;
        sample_cnt_next = sample_cnt;
        drain_cnt_next  = drain_cnt;
        done_next       = 1'b0;
        clear           = 1'b0;
        o_ready         = 1'b0;
        o_busy          = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_next      = RUN;
                    sample_cnt_next = '0;
                    clear           = 1'b1;
                end
            end
            RUN: begin
                o_ready = 1'b1;
                o_busy  = 1'b1;
                if (i_valid) begin
                    sample_cnt_next = sample_cnt + CNT_W'(1);
                    if (sample_cnt + CNT_W'(1) == LAST_CNT) begin
                        state_next     = DRAIN;
                        drain_cnt_next = 1'b0;
                    end
                end
            end
            DRAIN: begin
                o_busy = 1'b1;
                // Two cycles let the last sample pass S1 and S2 before done.
                if (drain_cnt) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    drain_cnt_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept = i_valid & o_ready;

    // One extra bit keeps the signed difference exact for any operand pair.
    assign diff = {i_approx[PROD_W-1], i_approx} - {i_exact[PROD_W-1], i_exact};
    assign ed   = diff[PROD_W] ? (~diff + (PROD_W+1)'(1)) : diff;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_ed    <= '0;
            s1_nz    <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_ed    <= ed;
            s1_nz    <= |diff;
        end
    end

    // Once the sum reaches all-ones it stays there, since ed is never negative.
    assign sum_wide = {1'b0, o_sum_ed} + (ACC_W+1)'(s1_ed);
    assign sum_sat  = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sum_ed  <= '0;
            o_max_ed  <= '0;
            o_err_cnt <= '0;
        end else if (clear) begin
            o_sum_ed  <= '0;
            o_max_ed  <= '0;
            o_err_cnt <= '0;
        end else if (s1_valid) begin
            o_sum_ed  <= sum_sat;
            o_err_cnt <= o_err_cnt + CNT_W'(s1_nz);
            if (s1_ed > o_max_ed) begin
                o_max_ed <= s1_ed;
            end
        end
    end

endmodule
